best_neighbor_finder: RTL
=========================

Name: best_neighbor_finder

Overview:
Upstream stage of winnerPolicy. On start, it scans the neighbour Q-value table held in the byte-wide node memory and finds the neighbour with the largest Q-value. It presents best_value and best_neighbor_id to winnerPolicy's _bestvalue and _bestneighborID inputs. Its level done drives winnerPolicy's done_prev.

Parameters:
ADDR_WIDTH, 10, memory byte-address width (1024-byte memory)
MEM_WIDTH, 8, memory data width
WORD_WIDTH, 16, Q-value and neighbour ID width
CNT_WIDTH, 8, neighbour count width (0..255 entries)

Ports:
clock  input  1  system clock, rising edge
nreset  input  1  asynchronous active-low reset
start  input  1  single-cycle scan request, sampled in IDLE only
table_base  input  ADDR_WIDTH  byte address of entry 0, sampled with start
neighbor_count  input  CNT_WIDTH  number of table entries, sampled with start
mem_rd  output  1  memory read strobe
mem_addr  output  ADDR_WIDTH  memory byte address
mem_data  input  MEM_WIDTH  read data, valid exactly 1 cycle after mem_rd
busy  output  1  high from the cycle after start until done rises
done  output  1  level; high when the result is valid, cleared by next accepted start
valid  output  1  high with done when at least one entry was scanned
best_value  output  WORD_WIDTH  best Q-value (IEEE binary16)
best_neighbor_id  output  WORD_WIDTH  ID of the best neighbour

Behaviour:
- Clock and reset: one clock, `clock`. Reset `nreset` is asynchronous and active-low.
- Reset values: state=IDLE, mem_rd=0, mem_addr=0, busy=0, done=0, valid=0, best_value=16'hFC00 (-inf), best_neighbor_id=16'hFFFF.
- Entry layout: 4 bytes per entry at table_base+4i: ID[7:0], ID[15:8], Q[7:0], Q[15:8] (little-endian).
- Address arithmetic: modulo 2^ADDR_WIDTH, so the scan wraps from 0x3FF to 0x000.
- States: IDLE, SCAN, FINISH.
- IDLE:
  - start=1 at cycle 0: latch base and count, clear done and valid, load best_value=FC00 and best_neighbor_id=FFFF.
  - If count=0, go to FINISH; else go to SCAN.
  - start while busy or in FINISH is ignored.
- SCAN:
  - mem_rd=1 on cycles 1..4N with mem_addr = base, base+1, …, base+4N-1, one byte per cycle, no bubbles.
  - Data for the read issued in cycle t is captured at cycle t+1 and assembled into an ID/Q pair.
  - Compare happens on the cycle the Q high byte is captured.
  - After the last byte is captured, go to FINISH.
- FINISH: assert done=1, clear busy, return to IDLE. done stays high in IDLE.
  - N>0: done rises at cycle 4N+2 after start.
  - N=0: done rises at cycle 2 with valid=0.
- Compare rule (binary16 total order):
  - key(x) = x[15] ? ~x : x | 16'h8000; compare keys as unsigned.
  - Update only when key(Q) > key(best), strictly greater, so the lowest index wins ties.
  - +0 and -0 compare unequal (+0 wins). NaN inputs are not produced upstream; their ordering is undefined.
- valid=1 whenever N>0, including when every Q is -inf.
- Reset mid-scan: return to the reset values immediately. No partial result is held; done stays 0 until a new start completes.
- start in the same cycle nreset deasserts is ignored.

Test Plan:
1. Basic max. base=0x010, N=3, entries (ID5,Q3C00) (ID7,Q4000) (ID9,QC000).
   -> mem_rd on cycles 1..12 with addresses 0x010..0x01B; done=1 at cycle 14; best_neighbor_id=7, best_value=0x4000, valid=1.
2. All negative. N=2, (ID1,QC000=-2.0) (ID2,QBC00=-1.0).
   -> best_neighbor_id=2, best_value=0xBC00.
3. Tie and zero sign. (ID3,Q3C00) (ID4,Q3C00) -> id=3. Separately (ID6,Q8000) (ID8,Q0000) -> id=8.
4. Empty table. N=0 -> no mem_rd; done=1 at cycle 2; valid=0; value=0xFC00; id=0xFFFF.
5. Wrap and protocol.
   - base=0x3FE, N=1: addresses 0x3FE, 0x3FF, 0x000, 0x001.
   - A second start pulse mid-scan is ignored.
   - done stays high until the next start, then drops on the cycle after that start.
6. Reset mid-scan. nreset=0 at cycle 5 of an N=3 scan -> all outputs at reset values asynchronously. A following start with N=1 completes normally, with done at cycle 6.

Source files
------------

// File: rtl/best_neighbor_finder.sv
// Scans a little-endian {ID, Q} neighbour table in byte-wide memory and keeps the
// entry with the largest binary16 Q-value, for winnerPolicy's best-value inputs.
module best_neighbor_finder #(
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_WIDTH  = 8,
    parameter int WORD_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] table_base,
    input  logic [CNT_WIDTH-1:0]  neighbor_count,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_WIDTH-1:0]  mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [WORD_WIDTH-1:0] best_value,
    output logic [WORD_WIDTH-1:0] best_neighbor_id
);

    localparam logic [WORD_WIDTH-1:0] NEG_INF = WORD_WIDTH'(16'hFC00);
    localparam logic [WORD_WIDTH-1:0] NO_ID   = '1;
    localparam int                    RD_WIDTH = CNT_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_t;

    state_t state;
    state_t next_state;

    logic                  armed;
    logic                  start_accept;
    logic                  count_nz;
    logic [RD_WIDTH-1:0]   rd_left;
    logic                  cap_en;
    logic [1:0]            cap_idx;
    logic [MEM_WIDTH-1:0]  id_lo;
    logic [MEM_WIDTH-1:0]  id_hi;
    logic [MEM_WIDTH-1:0]  q_lo;
    logic [WORD_WIDTH-1:0] q_word;
    logic                  q_better;

    // Maps binary16 onto an unsigned total order: negatives reversed below positives.
    function automatic logic [WORD_WIDTH-1:0] order_key(input logic [WORD_WIDTH-1:0] x);
        return x[WORD_WIDTH-1] ? ~x : {1'b1, x[WORD_WIDTH-2:0]};
    endfunction

    // NOTE: armed is cleared by reset and set by the first clock edge after release,
    // so a start coinciding with reset deassertion is never accepted.
    assign start_accept = (state == IDLE) && start && armed;

    assign q_word   = {mem_data, q_lo};
    assign q_better = order_key(q_word) > order_key(best_value);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start_accept) begin
                    next_state = (neighbor_count == '0) ? FINISH : SCAN;
                end
            end
            SCAN: begin
                if (rd_left == RD_WIDTH'(1)) begin
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read issue: one byte per cycle, 4 bytes per entry, address wraps naturally.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            armed    <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_left  <= '0;
            count_nz <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (start_accept) begin
                mem_addr <= table_base;
                rd_left  <= {neighbor_count, 2'b00};
                mem_rd   <= (neighbor_count != '0);
                count_nz <= (neighbor_count != '0);
            end else if (mem_rd) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
                rd_left  <= rd_left - RD_WIDTH'(1);
                if (rd_left == RD_WIDTH'(1)) begin
                    mem_rd <= 1'b0;
                end
            end
        end
    end

    // Capture: data returns one cycle after each read; the Q high byte triggers the compare.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cap_en           <= 1'b0;
            cap_idx          <= '0;
            id_lo            <= '0;
            id_hi            <= '0;
            q_lo             <= '0;
            best_value       <= NEG_INF;
            best_neighbor_id <= NO_ID;
        end else begin
            cap_en <= mem_rd;
            if (start_accept) begin
                cap_idx          <= '0;
                best_value       <= NEG_INF;
                best_neighbor_id <= NO_ID;
            end else if (cap_en) begin
                cap_idx <= cap_idx + 2'd1;
                unique case (cap_idx)
                    2'd0: id_lo <= mem_data;
                    2'd1: id_hi <= mem_data;
                    2'd2: q_lo  <= mem_data;
                    2'd3: begin
                        if (q_better) begin
                            best_value       <= q_word;
                            best_neighbor_id <= {id_hi, id_lo};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status: done is a level that persists in IDLE until the next accepted start.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
        end else begin
            if (start_accept) begin
                busy  <= 1'b1;
                done  <= 1'b0;
                valid <= 1'b0;
            end else if (state == FINISH) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                valid <= count_nz;
            end
        end
    end

endmodule
